vector_ram_gather: RTL
======================

# vector_ram_gather

SpMV gather front-end and the initiator side of the vector RAM request/response protocol. Each run has two phases. First it fills the vector RAM with a dense x vector, streamed PARALLELISM elements per beat to sequential addresses. Then it turns a stream of column-index groups into random-access read requests and returns the gathered x values in request order. It sits between the CSR column-index reader and the multiply lanes, and bounds in-flight reads with a credit counter.

## Interface
Parameters:
- PARALLELISM, 4: lanes per beat (power of 2).
- DATA_WIDTH, 32: element width.
- ADDR_WIDTH, 16: element address width.
- VECTOR_LENGTH, 32: elements in x; must be a multiple of PARALLELISM.
- MAX_OUTSTANDING, 4: maximum read beats in flight; also the depth of the response and tag FIFOs.

Ports (arrays are PARALLELISM lanes):
- Reset policy (already decided): one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a run; honoured only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of run.
- fill_valid / fill_ready  in/out  1  dense x beat handshake.
- fill_data  in  DATA_WIDTH x P  x elements.
- idx_valid / idx_ready  in/out  1  index beat handshake.
- idx_data  in  ADDR_WIDTH x P  column indices.
- idx_last  in  1  final index beat of the run.
- out_valid / out_ready  out/in  1  gathered beat handshake.
- out_data  out  DATA_WIDTH x P  gathered values.
- out_last  out  1  beat corresponds to idx_last.
- ram_wvalid / ram_wready  out/in  1  write request.
- ram_waddr, ram_wdata  out  ADDR_WIDTH x P, DATA_WIDTH x P.
- ram_arvalid / ram_arready  out/in  1  read request.
- ram_araddr  out  ADDR_WIDTH x P.
- ram_rvalid / ram_rready  in/out  1  read response.
- ram_rdata  in  DATA_WIDTH x P.

## Operation
States: IDLE, FILL, GATHER, DRAIN, DONE.

- **IDLE**
  - start=1 moves to FILL with fill_base=0 and credits=MAX_OUTSTANDING.
  - fill_ready, idx_ready and ram_wvalid/ram_arvalid are 0.
  - ram_rready=1; any stray response is discarded.
- **FILL**
  - ram_wvalid=fill_valid and fill_ready=ram_wready.
  - ram_waddr[k]=fill_base+k and ram_wdata=fill_data.
  - On a write handshake fill_base += PARALLELISM.
  - When the accepted beat has fill_base+PARALLELISM == VECTOR_LENGTH, go to GATHER.
- **GATHER**
  - A request can issue only when credits>0.
  - When it can, ram_arvalid=idx_valid and idx_ready=ram_arready; otherwise both are 0.
  - Per lane, ram_araddr[k]=idx_data[k] if idx_data[k]<VECTOR_LENGTH, else 0.
  - On issue, credits decrement and the tag FIFO pushes {lane out-of-range mask, idx_last}.
  - Issuing the beat with idx_last=1 moves to DRAIN; idx_ready is then held 0.
- **Responses**
  - Responses return in request order.
  - On a ram_rvalid&&ram_rready handshake, push ram_rdata into the response FIFO. Lanes flagged in the tag mask are forced to 0.
  - ram_rready=!resp_fifo_full. Credits guarantee the FIFO never overflows.
  - out_last comes from the tag entry.
  - On an out_valid&&out_ready handshake, pop the response and tag FIFOs and increment credits.
  - A simultaneous issue and release leaves credits unchanged.
- **DRAIN**
  - Wait for the out handshake carrying out_last=1, then go to DONE.
- **DONE**
  - done=1 for one cycle, then go to IDLE.
- Width rules:
  - credits is $clog2(MAX_OUTSTANDING+1) bits.
  - fill_base is ADDR_WIDTH bits; it never wraps because the run ends at VECTOR_LENGTH.
- Range check: index comparison is unsigned.

## Timing
- Reset values:
  - State goes to IDLE.
  - busy=0, done=0, fill_ready=0, idx_ready=0, out_valid=0, out_last=0.
  - ram_wvalid=0, ram_arvalid=0, ram_rready=1.
  - credits=MAX_OUTSTANDING and both FIFOs are empty.
- Reset mid-run aborts immediately; in-flight responses arriving afterwards are drained and dropped in IDLE.
- Request path latency is 0 cycles: ram_wvalid and ram_arvalid follow fill_valid and idx_valid combinationally within a state.
- Response-to-output latency: out_valid asserts the cycle after the ram_rvalid handshake.
- out_data and out_last are held stable while out_valid=1 and out_ready=0.
- busy goes high the cycle after start is accepted.
- done pulses the cycle after the out_last handshake.
- start asserted while busy is ignored.
- A run with idx_last on the first beat is legal.

## Test plan
- **Fill:** start, then 8 fill beats (P=4, VL=32) of data i+100 → waddr groups 0..3, 4..7, …, 28..31 with matching wdata; GATHER entered after the 8th handshake.
- **In-order gather:** indices {3,0,31,17}, {5,5,5,5 last} against a RAM with 1-cycle latency → out_data {103,100,131,117} then {105,105,105,105} with out_last=1; done pulses once.
- **Credit limit:** out_ready=0 for 20 cycles with 6 index beats queued → exactly 4 read requests issue and ram_arvalid is 0 afterwards; on releasing out_ready the remaining 2 issue and order is preserved.
- **Out of range:** index {40,1,65535,2} → ram_araddr {0,1,0,2}; out_data {0,101,0,102}.
- **Backpressure on both sides:** random ram_wready, ram_arready and out_ready toggling over 50 beats → no beat lost or duplicated, and out_data is stable while stalled.
- **Reset mid-GATHER:** assert rst with 3 reads outstanding → busy=0 and all valids 0 immediately; late ram_rvalid beats accepted and discarded; a new start completes a clean run.

Source files
------------

// File: rtl/vector_ram_gather.sv
// SpMV gather front-end: fills the vector RAM with a dense x vector, then turns
// column-index beats into credit-bounded RAM reads and returns the values in order.
module vector_ram_gather #(
  parameter int PARALLELISM     = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int VECTOR_LENGTH   = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   fill_valid,
  output logic                                   fill_ready,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] fill_data,
  input  logic                                   idx_valid,
  output logic                                   idx_ready,
  input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] idx_data,
  input  logic                                   idx_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] out_data,
  output logic                                   out_last,
  output logic                                   ram_wvalid,
  input  logic                                   ram_wready,
  output logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] ram_waddr,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] ram_wdata,
  output logic                                   ram_arvalid,
  input  logic                                   ram_arready,
  output logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] ram_araddr,
  input  logic                                   ram_rvalid,
  output logic                                   ram_rready,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] ram_rdata
);
  // state  | meaning
  // IDLE   | waiting for start; stray read responses are sunk
  // FILL   | writing dense x beats to sequential RAM addresses
  // GATHER | issuing index beats as reads, bounded by credits
  // DRAIN  | final index issued; waiting for the out_last beat to leave
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_GATHER, S_DRAIN, S_DONE} state_t;

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0]         CREDITS_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0]         PTR_LAST    = PW'(MAX_OUTSTANDING - 1);
  localparam logic [ADDR_WIDTH-1:0] VL_A        = ADDR_WIDTH'(VECTOR_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] P_A         = ADDR_WIDTH'(PARALLELISM);

  state_t                                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]                  fill_base;
  logic [CW-1:0]                          credits;
  logic [CW-1:0]                          resp_count;
  logic [PW-1:0]                          tag_wptr, resp_wptr, rd_ptr;
  logic [PARALLELISM-1:0]                 tag_mask_mem [MAX_OUTSTANDING];
  logic                                   tag_last_mem [MAX_OUTSTANDING];
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] resp_mem     [MAX_OUTSTANDING];
  logic [PARALLELISM-1:0]                 oor_mask;
  logic [PARALLELISM-1:0]                 push_mask;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] push_data;
  logic fill_hs, can_issue, issue, resp_full, resp_push, release_beat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < PARALLELISM; k++) begin
      oor_mask[k]   = (idx_data[k] >= VL_A);
      ram_araddr[k] = oor_mask[k] ? '0 : idx_data[k];
      ram_waddr[k]  = fill_base + ADDR_WIDTH'(k);
    end
  end

  // A zero-latency response belongs to the tag being written this very cycle.
  assign push_mask = (issue && (tag_wptr == resp_wptr)) ? oor_mask : tag_mask_mem[resp_wptr];

  always_comb begin
    for (int k = 0; k < PARALLELISM; k++)
      push_data[k] = push_mask[k] ? '0 : ram_rdata[k];
  end

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign ram_wvalid   = (state == S_FILL) && fill_valid;
  assign fill_ready   = (state == S_FILL) && ram_wready;
  assign ram_wdata    = fill_data;
  assign fill_hs      = ram_wvalid && ram_wready;
  assign can_issue    = (state == S_GATHER) && (credits != '0);
  assign ram_arvalid  = can_issue && idx_valid;
  assign idx_ready    = can_issue && ram_arready;
  assign issue        = ram_arvalid && ram_arready;
  assign resp_full    = (resp_count == CREDITS_MAX);
  assign ram_rready   = !resp_full;
  assign resp_push    = ram_rvalid && ram_rready && ((state == S_GATHER) || (state == S_DRAIN));
  assign out_valid    = (resp_count != '0);
  assign out_data     = resp_mem[rd_ptr];
  assign out_last     = out_valid && tag_last_mem[rd_ptr];
  assign release_beat = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FILL;
      S_FILL:   if (fill_hs && (fill_base + P_A == VL_A)) state_nxt = S_GATHER;
      S_GATHER: if (issue && idx_last) state_nxt = S_DRAIN;
      S_DRAIN:  if (release_beat && out_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      fill_base  <= '0;
      credits    <= CREDITS_MAX;
      resp_count <= '0;
      tag_wptr   <= '0;
      resp_wptr  <= '0;
      rd_ptr     <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start) begin
        fill_base <= '0;
        credits   <= CREDITS_MAX;
      end else begin
        if (fill_hs) fill_base <= fill_base + P_A;
        case ({issue, release_beat})
          2'b10:   credits <= credits - CW'(1);
          2'b01:   credits <= credits + CW'(1);
          default: credits <= credits;
        endcase
      end
      case ({resp_push, release_beat})
        2'b10:   resp_count <= resp_count + CW'(1);
        2'b01:   resp_count <= resp_count - CW'(1);
        default: resp_count <= resp_count;
      endcase
      if (issue)        tag_wptr  <= ptr_inc(tag_wptr);
      if (resp_push)    resp_wptr <= ptr_inc(resp_wptr);
      if (release_beat) rd_ptr    <= ptr_inc(rd_ptr);
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mask_mem[tag_wptr] <= oor_mask;
      tag_last_mem[tag_wptr] <= idx_last;
    end
    if (resp_push) resp_mem[resp_wptr] <= push_data;
  end

endmodule
